// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the 8-line direct-mapped cache and its refill path:
// line/word geometry, address field bounds, the refill FSM state encoding and
// a helper that forms a line base address from a byte address.
// -----------------------------------------------------------------------------
package cache_pkg;

    localparam int LINE_W         = 128;
    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 4;

    // Byte-address field bounds: | tag | index | word offset | byte |
    localparam int TAG_MSB = 31;
    localparam int TAG_LSB = 7;
    localparam int IDX_MSB = 6;
    localparam int IDX_LSB = 4;
    localparam int OFF_MSB = 3;
    localparam int OFF_LSB = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } refill_state_t;

    // Base byte address of the line containing addr (offset and byte bits cleared).
    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return {addr[TAG_MSB:IDX_LSB], 4'b0000};
    endfunction

endpackage

// File: rtl/refill_mem_array.sv
// -----------------------------------------------------------------------------
// refill_mem_array
// Word-wide backing memory: MEM_WORDS x 32 bits, one synchronous write port
// and one asynchronous (combinational) read port. Contents are not reset.
//
// Ports:
//   clk        in   clock, rising edge
//   i_wr_en    in   write enable
//   i_wr_idx   in   word index to write
//   i_wr_data  in   write data
//   i_rd_idx   in   word index to read
//   o_rd_data  out  read data (current array contents, old value on a
//                   same-cycle write to the same word)
// -----------------------------------------------------------------------------
module refill_mem_array
    import cache_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [WORD_W-1:0] o_rd_data
);

    logic [WORD_W-1:0] r_mem [MEM_WORDS];

    // Synchronous word write.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl
// Memory-side refill responder for the direct-mapped cache. A miss request
// accepted in IDLE waits MEM_LATENCY cycles, then reads the four words of the
// line one per cycle from the backing memory, assembles them into a 128-bit
// line and strobes line_valid for one cycle with the line base address.
// A word write port into the backing memory is honoured in every state.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   miss_req    in   miss request, sampled only in IDLE
//   miss_addr   in   byte address of the missing access
//   wr_en       in   backing-memory word write enable
//   wr_addr     in   byte address of the write (bits [1:0] ignored)
//   wr_data     in   write data
//   line_data   out  assembled line, word 0 in [127:96] ... word 3 in [31:0]
//   line_addr   out  line base address, updated when the line completes
//   line_valid  out  one-cycle strobe, line_data/line_addr valid for the fill
//   busy        out  refill in progress, new requests ignored
// -----------------------------------------------------------------------------
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_req,
    input  logic [31:0]       miss_addr,
    input  logic              wr_en,
    input  logic [31:0]       wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    output logic [LINE_W-1:0] line_data,
    output logic [31:0]       line_addr,
    output logic              line_valid,
    output logic              busy
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    refill_state_t     r_state;
    refill_state_t     w_next_state;
    logic [3:0]        r_lat_cnt;
    logic [3:0]        w_lat_cnt_nxt;
    logic [1:0]        r_beat;
    logic [1:0]        w_beat_nxt;
    logic              w_capture;
    logic              w_load_word;
    logic [31:0]       r_line_addr;      // captured request line base
    logic [31:0]       r_line_addr_out;  // published with the strobe
    logic [LINE_W-1:0] r_line_data;
    logic              r_line_valid;
    logic              r_busy;

    logic [IDX_W-1:0]  w_rd_idx;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [WORD_W-1:0] w_rd_data;
    logic              w_unused;

    // Line base has zero word-offset bits, so OR-ing the beat in forms the
    // word index; upper address bits beyond the array are dropped (wrap).
    assign w_rd_idx = r_line_addr[IDX_W+1:2] | IDX_W'(r_beat);
    assign w_wr_idx = wr_addr[IDX_W+1:2];

    assign w_unused = ^{miss_addr[3:0], wr_addr[1:0], wr_addr[31:IDX_W+2],
                        r_line_addr[3:0]};

    refill_mem_array #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (wr_en),
        .i_wr_idx  (w_wr_idx),
        .i_wr_data (wr_data),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data)
    );

    // Next-state, counter and datapath-enable decode.
    always_comb begin
        w_next_state  = r_state;
        w_lat_cnt_nxt = r_lat_cnt;
        w_beat_nxt    = r_beat;
        w_capture     = 1'b0;
        w_load_word   = 1'b0;
        case (r_state)
            IDLE: begin
                if (miss_req) begin
                    w_next_state  = WAIT;
                    w_lat_cnt_nxt = 4'(MEM_LATENCY - 1);
                    w_capture     = 1'b1;
                end else begin
                    w_next_state  = IDLE;
                end
            end
            WAIT: begin
                if (r_lat_cnt == 4'd0) begin
                    w_next_state = BURST;
                    w_beat_nxt   = 2'd0;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt - 4'd1;
                end
            end
            BURST: begin
                w_load_word = 1'b1;
                w_beat_nxt  = r_beat + 2'd1;
                if (r_beat == 2'd3) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = BURST;
                end
            end
            DONE: begin
                // A request seen here is not accepted; it must still be high
                // in the following IDLE cycle.
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State, counters, line assembly and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_lat_cnt       <= 4'd0;
            r_beat          <= 2'd0;
            r_line_addr     <= 32'd0;
            r_line_addr_out <= 32'd0;
            r_line_data     <= {LINE_W{1'b0}};
            r_line_valid    <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_lat_cnt <= w_lat_cnt_nxt;
            r_beat    <= w_beat_nxt;
            if (w_capture) begin
                r_line_addr <= line_base(miss_addr);
            end
            if (w_load_word) begin
                // Beat 0 is the lowest-addressed word and lands in the MSBs.
                case (r_beat)
                    2'd0:    r_line_data[127:96] <= w_rd_data;
                    2'd1:    r_line_data[95:64]  <= w_rd_data;
                    2'd2:    r_line_data[63:32]  <= w_rd_data;
                    2'd3:    r_line_data[31:0]   <= w_rd_data;
                    default: r_line_data[31:0]   <= w_rd_data;
                endcase
            end
            if (w_next_state == DONE) begin
                r_line_addr_out <= r_line_addr;
            end
            r_line_valid <= (w_next_state == DONE);
            r_busy       <= (w_next_state != IDLE);
        end
    end

    assign line_data  = r_line_data;
    assign line_addr  = r_line_addr_out;
    assign line_valid = r_line_valid;
    assign busy       = r_busy;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
module tb_cache_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         miss_req = 1'b0;
    logic [31:0]  miss_addr = 32'd0;
    logic         miss_req1 = 1'b0;
    logic [31:0]  miss_addr1 = 32'd0;
    logic         wr_en = 1'b0;
    logic [31:0]  wr_addr = 32'd0;
    logic [31:0]  wr_data = 32'd0;
    logic [127:0] line_data, line_data1;
    logic [31:0]  line_addr, line_addr1;
    logic         line_valid, line_valid1;
    logic         busy, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // LAT=2 instance: main refill tests.
    cache_refill_ctrl #(.MEM_WORDS(1024), .MEM_LATENCY(2)) u_dut (
        .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .line_data(line_data), .line_addr(line_addr),
        .line_valid(line_valid), .busy(busy));

    // LAT=1 instance: shares the write port so both memories hold the same data.
    cache_refill_ctrl #(.MEM_WORDS(1024), .MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .miss_req(miss_req1), .miss_addr(miss_addr1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .line_data(line_data1), .line_addr(line_addr1),
        .line_valid(line_valid1), .busy(busy1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Issue a one-cycle request and count edges until line_valid (bounded).
    task automatic do_refill(input logic [31:0] a, output int n);
        miss_req = 1'b1; miss_addr = a;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) miss_req = 1'b0;
        end while (!line_valid && n < 40);
    endtask

    initial begin
        int n;
        int strobes;

        // ---------------- reset ----------------
        rst = 1'b1;
        tick(); tick();
        chk("rst_valid", 128'(line_valid), 128'd0);
        chk("rst_busy",  128'(busy),       128'd0);
        chk("rst_data",  line_data,        128'd0);
        chk("rst_addr",  128'(line_addr),  128'd0);
        rst = 1'b0;
        tick();

        // ---------------- preload ----------------
        for (int i = 0; i < 4; i++) begin
            write_word(32'h40 + 32'(4*i), 32'hA000_0000 + 32'(i));
            write_word(32'h10 + 32'(4*i), 32'hB000_0004 + 32'(i));
            write_word(32'h20 + 32'(4*i), 32'hC000_0008 + 32'(i));
            write_word(32'h80 + 32'(4*i), 32'hD000_0020 + 32'(i));
        end

        // ------- basic refill with an ignored request on edge 3 -------
        miss_req = 1'b1; miss_addr = 32'h0000_004C;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) miss_req = 1'b0;
            if (k == 2) begin miss_req = 1'b1; miss_addr = 32'h0000_0080; end
            if (k == 3) miss_req = 1'b0;
            chk($sformatf("basic_busy_e%0d", k), 128'(busy), 128'd1);
            chk($sformatf("basic_valid_e%0d", k), 128'(line_valid), (k == 7) ? 128'd1 : 128'd0);
        end
        chk("basic_addr", 128'(line_addr), 128'h40);
        chk("basic_data", line_data, 128'hA0000000_A0000001_A0000002_A0000003);
        tick();
        chk("basic_busy_fall", 128'(busy), 128'd0);
        chk("basic_hold_data", line_data, 128'hA0000000_A0000001_A0000002_A0000003);
        strobes = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (line_valid) strobes++;
        end
        chk("busy_req_ignored", 128'(strobes), 128'd0);

        // ------- re-issue the ignored request -------
        do_refill(32'h0000_0080, n);
        chk("reissue_lat",  128'(n), 128'd7);
        chk("reissue_addr", 128'(line_addr), 128'h80);
        chk("reissue_data", line_data, 128'hD0000020_D0000021_D0000022_D0000023);
        tick(); tick();

        // ------- write collision on beat 1 -------
        miss_req = 1'b1; miss_addr = 32'h0000_0040;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) miss_req = 1'b0;
            if (k == 4) begin wr_en = 1'b1; wr_addr = 32'h44; wr_data = 32'hDEAD_BEEF; end
            if (k == 5) wr_en = 1'b0;
        end
        chk("coll_valid", 128'(line_valid), 128'd1);
        chk("coll_old_data", line_data, 128'hA0000000_A0000001_A0000002_A0000003);
        tick(); tick();
        do_refill(32'h0000_0040, n);
        chk("coll_new_lat",  128'(n), 128'd7);
        chk("coll_new_data", line_data, 128'hA0000000_DEADBEEF_A0000002_A0000003);
        tick(); tick();

        // ------- reset mid-burst -------
        miss_req = 1'b1; miss_addr = 32'h0000_0010;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) miss_req = 1'b0;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy",  128'(busy),       128'd0);
        chk("midrst_valid", 128'(line_valid), 128'd0);
        chk("midrst_data",  line_data,        128'd0);
        chk("midrst_addr",  128'(line_addr),  128'd0);
        strobes = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (line_valid) strobes++;
        end
        chk("midrst_no_strobe", 128'(strobes), 128'd0);

        // ------- fresh request after reset, with address wrap -------
        do_refill(32'h0000_1010, n);
        chk("wrap_lat",  128'(n), 128'd7);
        chk("wrap_addr", 128'(line_addr), 128'h1010);
        chk("wrap_data", line_data, 128'hB0000004_B0000005_B0000006_B0000007);
        tick(); tick();

        // ------- LAT=1 build, request held high -------
        // Each refill is IDLE + 1 WAIT + 4 BURST + DONE, so with miss_req
        // held the strobes repeat every 7 edges (IDLE is the only gap).
        miss_req1 = 1'b1; miss_addr1 = 32'h0000_0020;
        for (int r = 0; r < 3; r++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!line_valid1 && n < 40);
            chk($sformatf("lat1_interval_%0d", r), 128'(n), (r == 0) ? 128'd6 : 128'd7);
            chk($sformatf("lat1_data_%0d", r), line_data1, 128'hC0000008_C0000009_C000000A_C000000B);
            chk($sformatf("lat1_addr_%0d", r), 128'(line_addr1), 128'h20);
        end
        miss_req1 = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
